// File: rtl/primitive_sequencer_pkg.sv
// Shared opcodes, topology modes and FSM encoding for the triangle-assembly front end.
// Pure declarations: no latency, no backpressure.
package mch3d_pkg;

    localparam logic [1:0] OP_SET_CMD = 2'b00;
    localparam logic [1:0] OP_BEGIN   = 2'b01;
    localparam logic [1:0] OP_END     = 2'b10;

    localparam logic [1:0] MODE_LIST  = 2'd0;
    localparam logic [1:0] MODE_STRIP = 2'd1;
    localparam logic [1:0] MODE_FAN   = 2'd2;

    localparam int VTX_BYTES = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_COUNT,
        ST_VTX,
        ST_EMIT
    } state_t;

    typedef struct packed {
        logic       due;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
    } emit_t;

endpackage

// File: rtl/primitive_sequencer_if.sv
// Host byte stream, vertex-slot write port and triangle request bundle.
// master = host/assembler side, slave = sequencer.
interface primitive_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic [1:0] v_sel;
    logic [2:0] v_addr;
    logic [7:0] v_data;
    logic       v_we;
    logic [7:0] command;
    logic [1:0] va_sel;
    logic [1:0] vb_sel;
    logic [1:0] vc_sel;
    logic       write;
    logic       vertices_full;

    modport master (
        output in_data, in_valid, vertices_full,
        input  in_ready, busy, v_sel, v_addr, v_data, v_we,
               command, va_sel, vb_sel, vc_sel, write
    );

    modport slave (
        input  in_data, in_valid, vertices_full,
        output in_ready, busy, v_sel, v_addr, v_data, v_we,
               command, va_sel, vb_sel, vc_sel, write
    );
endinterface

// File: rtl/primitive_sequencer.sv
// Parses command/header/vertex bytes, writes vertex slots one cycle after each byte, requests triangles.
// Triangle request one idle cycle after the final vertex byte; input stalls in EMIT until write fires (write held off by vertices_full).
module primitive_sequencer
    import mch3d_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    primitive_sequencer_if.slave bus
);

    function automatic logic [1:0] slot_of(input logic [1:0] m, input logic [7:0] idx);
        if (m == MODE_FAN)
            return (idx == 8'd0) ? 2'd0 : 2'd1 + 2'((idx - 8'd1) % 8'd3);
        return idx[1:0];
    endfunction

    function automatic emit_t emit_of(input logic [1:0] m, input logic [7:0] idx);
        emit_t e;
        e.due = 1'b0;
        e.a   = slot_of(m, idx - 8'd2);
        e.b   = slot_of(m, idx - 8'd1);
        e.c   = slot_of(m, idx);
        case (m)
            MODE_LIST:  e.due = ((idx % 8'd3) == 8'd2);
            MODE_STRIP: begin
                e.due = (idx >= 8'd2);
                // Odd strip triangles swap the first two corners to keep winding consistent.
                if (idx[0]) begin
                    e.a = slot_of(m, idx - 8'd1);
                    e.b = slot_of(m, idx - 8'd2);
                end
            end
            MODE_FAN: begin
                e.due = (idx >= 8'd2);
                e.a   = 2'd0;
            end
            default: e.due = 1'b0;
        endcase
        return e;
    endfunction

    state_t     state;
    logic [1:0] mode;
    logic [7:0] count;
    logic [7:0] k;
    logic [2:0] b;
    logic       emit_arm;
    logic [7:0] command_q;
    logic [1:0] v_sel_q, va_q, vb_q, vc_q;
    logic [2:0] v_addr_q;
    logic [7:0] v_data_q;
    logic       v_we_q;

    logic  in_ready_w;
    logic  accept;
    logic  write_w;
    logic  last_vtx;
    logic  more_vtx;
    emit_t emit_now;

    assign in_ready_w = (state != ST_EMIT);
    assign accept     = bus.in_valid & in_ready_w;
    // emit_arm stays low for the cycle the final slot byte is being written.
    assign write_w    = (state == ST_EMIT) & emit_arm & ~bus.vertices_full;
    assign last_vtx   = (({1'b0, k} + 9'd1) == {1'b0, count});
    assign more_vtx   = (({1'b0, k} + 9'd1) <  {1'b0, count});
    assign emit_now   = emit_of(mode, k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode      <= MODE_LIST;
            count     <= 8'd0;
            k         <= 8'd0;
            b         <= 3'd0;
            emit_arm  <= 1'b0;
            command_q <= 8'd0;
            v_sel_q   <= 2'd0;
            v_addr_q  <= 3'd0;
            v_data_q  <= 8'd0;
            v_we_q    <= 1'b0;
            va_q      <= 2'd0;
            vb_q      <= 2'd0;
            vc_q      <= 2'd0;
        end else begin
            v_we_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.in_data[7:6])
                            OP_SET_CMD: state <= ST_CMD;
                            OP_BEGIN: begin
                                if (bus.in_data[1:0] != 2'd3) begin
                                    mode  <= bus.in_data[1:0];
                                    state <= ST_COUNT;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        command_q <= bus.in_data;
                        state     <= ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        count <= bus.in_data;
                        k     <= 8'd0;
                        b     <= 3'd0;
                        state <= (bus.in_data == 8'd0) ? ST_IDLE : ST_VTX;
                    end
                end
                ST_VTX: begin
                    if (accept) begin
                        v_we_q   <= 1'b1;
                        v_data_q <= bus.in_data;
                        v_addr_q <= b;
                        v_sel_q  <= slot_of(mode, k);
                        if (b == 3'(VTX_BYTES - 1)) begin
                            if (emit_now.due) begin
                                va_q     <= emit_now.a;
                                vb_q     <= emit_now.b;
                                vc_q     <= emit_now.c;
                                emit_arm <= 1'b0;
                                state    <= ST_EMIT;
                            end else if (last_vtx) begin
                                state <= ST_IDLE;
                            end else begin
                                k <= k + 8'd1;
                                b <= 3'd0;
                            end
                        end else begin
                            b <= b + 3'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    emit_arm <= 1'b1;
                    if (write_w) begin
                        if (more_vtx) begin
                            k     <= k + 8'd1;
                            b     <= 3'd0;
                            state <= ST_VTX;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.write    = write_w;
    assign bus.command  = command_q;
    assign bus.v_sel    = v_sel_q;
    assign bus.v_addr   = v_addr_q;
    assign bus.v_data   = v_data_q;
    assign bus.v_we     = v_we_q;
    assign bus.va_sel   = va_q;
    assign bus.vb_sel   = vb_q;
    assign bus.vc_sel   = vc_q;

endmodule
